pdec_sched_ctrl: RTL

- Successive-cancellation schedule sequencer for the polar decoder. It steps the bit index 0..N-1 and reads the per-bit depth value from the depth ROM, which sits directly downstream on its address port.
- It turns each depth value into an ordered stream of tree operations (F, G, LEAF, PSUM) with stage numbers. The stream drives the decoder datapath over a valid/ready handshake.
- One frame is scheduled per start pulse.

---
 rtl/pdec_sched_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pdec_sched_ctrl.sv
// rtl/pdec_sched_ctrl.sv - successive-cancellation schedule sequencer for the polar decoder
//
// Steps the bit index through one frame, fetches each bit's depth from the
// depth ROM and emits the ordered tree operations F / G / LEAF / PSUM with
// their stage over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle frame start (ignored while busy)
//   busy, done      frame in progress / one-cycle end-of-frame pulse
//   err             sticky out-of-range depth flag, cleared by an accepted start
//   rom_ce, rom_we  ROM read enable / write enable (always 0)
//   rom_addr        ROM address, holds its last value between reads
//   rom_rdata       ROM data, valid one cycle after rom_ce
//   op_valid/ready  operation handshake
//   op_type         0=F 1=G 2=LEAF 3=PSUM
//   op_stage        tree stage, 0 = leaf level
//   op_bit          current bit index
module pdec_sched_ctrl #(
    parameter int N     = 512,
    parameter int LOG2N = $clog2(N),
    parameter int DW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rom_ce,
    output logic             rom_we,
    output logic [LOG2N-1:0] rom_addr,
    input  logic [DW-1:0]    rom_rdata,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_type,
    output logic [DW-1:0]    op_stage,
    output logic [LOG2N-1:0] op_bit
);

    typedef enum logic [2:0] {
        S_IDLE, S_DESC, S_LEAF, S_FETCH, S_WAIT, S_PSUM, S_GOP, S_DONE
    } state_t;

    localparam logic [1:0]       OP_F      = 2'd0;
    localparam logic [1:0]       OP_G      = 2'd1;
    localparam logic [1:0]       OP_LEAF   = 2'd2;
    localparam logic [1:0]       OP_PSUM   = 2'd3;
    localparam logic [DW-1:0]    TOP_STAGE = DW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] LAST_BIT  = LOG2N'(N - 1);

    state_t           state, state_nxt;
    logic [LOG2N-1:0] bit_idx;
    logic [DW-1:0]    stage;
    logic [DW-1:0]    depth;
    logic             xfer;
    logic             depth_over;
    logic [DW-1:0]    depth_in;

    assign xfer       = op_valid & op_ready;
    assign rom_we     = 1'b0;
    // A depth beyond the tree height cannot be scheduled; flag it and clamp.
    assign depth_over = rom_rdata > TOP_STAGE;
    assign depth_in   = depth_over ? TOP_STAGE : rom_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DESC;
            S_DESC:  if (xfer && stage == '0) state_nxt = S_LEAF;
            S_LEAF:  if (xfer) state_nxt = (bit_idx == LAST_BIT) ? S_DONE : S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_PSUM;
            S_PSUM:  if (xfer && stage == depth) state_nxt = S_GOP;
            S_GOP:   if (xfer) state_nxt = (depth == '0) ? S_LEAF : S_DESC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit index, stage counter, captured depth, sticky error and ROM address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx  <= '0;
            stage    <= '0;
            depth    <= '0;
            err      <= 1'b0;
            rom_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bit_idx <= '0;
                        stage   <= TOP_STAGE;
                        err     <= 1'b0;
                    end
                end
                S_DESC: begin
                    if (xfer && stage != '0) stage <= stage - DW'(1);
                end
                S_LEAF: begin
                    // Load the address here so it is already on the port in FETCH.
                    if (xfer && bit_idx != LAST_BIT) rom_addr <= bit_idx;
                end
                S_WAIT: begin
                    depth <= depth_in;
                    stage <= '0;
                    if (depth_over) err <= 1'b1;
                end
                S_PSUM: begin
                    if (xfer) begin
                        if (stage == depth) begin
                            bit_idx <= bit_idx + LOG2N'(1);
                        end else begin
                            stage <= stage + DW'(1);
                        end
                    end
                end
                S_GOP: begin
                    if (xfer && depth != '0) stage <= depth - DW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rom_ce   = 1'b0;
        op_valid = 1'b0;
        op_type  = OP_F;
        op_stage = '0;
        op_bit   = '0;
        case (state)
            S_DESC: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_type  = OP_F;
                op_stage = stage;
                op_bit   = bit_idx;
            end
            S_LEAF: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_type  = OP_LEAF;
                op_bit   = bit_idx;
            end
            S_FETCH: begin
                busy   = 1'b1;
                rom_ce = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            S_PSUM: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_type  = OP_PSUM;
                op_stage = stage;
                op_bit   = bit_idx;
            end
            S_GOP: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_type  = OP_G;
                op_stage = stage;
                op_bit   = bit_idx;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
